// File: rtl/ram_512x32.sv
// ram_512x32: single-port synchronous word memory for processor Z.
// The host loads program and data through the write port while the core is
// idle. The fetch stage then reads words (address = PC) through the
// registered read port. Reads have one cycle of latency. A simultaneous read
// and write to the same port returns the new data (write-first).
module ram_512x32 #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage array. Every word starts at zero so the fetch stage never sees
    // X on a word the host has not loaded. Reset leaves the contents untouched.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1] = '{default: '0};

    // Registered read data. Only this register is cleared by reset.
    logic [DATA_W-1:0] r_rdata;

    // Qualified strobes. Reset masks both ports, so a reset cycle neither
    // writes the array nor loads the read register from it.
    logic w_doWrite;
    logic w_doRead;

    assign w_doWrite = wr && !reset;
    assign w_doRead  = rd && !reset;

    // Array write: the addressed word takes wdata at the clock edge.
    always_ff @(posedge clock) begin
        if (w_doWrite) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register: cleared by reset, write-first on a simultaneous
    // read and write, and held when no read is requested.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_doRead) begin
            if (wr) begin
                r_rdata <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_ram_512x32.sv
// Self-checking bench for ram_512x32. A reference memory model predicts
// rdata for every driven cycle. The prediction is queued and then compared
// after the clock edge. Extra literal checks pin the values the design is
// expected to return in the directed scenarios.
module tb_ram_512x32;

    logic        clock;
    logic        reset;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;

    int assertCount;
    int failCount;

    logic [31:0] modelMem [512];
    logic [31:0] modelRdata;
    logic [31:0] expQueue [$];
    string       tagQueue [$];

    ram_512x32 dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rd    (rd),
        .rdata (rdata)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge. Push the predicted rdata.
    // After the rising edge, pop the prediction and check it.
    task automatic applyStimulus(input string tag, input logic rst, input logic w,
                                 input logic r, input logic [8:0] a,
                                 input logic [31:0] d);
        logic [31:0] exp;
        string       expTag;
        @(negedge clock);
        reset = rst;
        wr    = w;
        rd    = r;
        addr  = a;
        wdata = d;
        if (rst) begin
            modelRdata = 32'h0;
        end else begin
            if (r) modelRdata = w ? d : modelMem[a];
            if (w) modelMem[a] = d;
        end
        expQueue.push_back(modelRdata);
        tagQueue.push_back(tag);
        @(posedge clock);
        #1;
        exp    = expQueue.pop_front();
        expTag = tagQueue.pop_front();
        checkOutput(expTag, rdata, exp);
    endtask

    logic [31:0] loadWords [5];

    initial begin
        assertCount = 0;
        failCount   = 0;
        modelRdata  = 32'h0;
        for (int i = 0; i < 512; i++) modelMem[i] = 32'h0;
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;

        loadWords[0] = 32'h10F00010;
        loadWords[1] = 32'h20010000;
        loadWords[2] = 32'h21230000;
        loadWords[3] = 32'h22450000;
        loadWords[4] = 32'h23670000;

        // Reset with rd=1 and a stray write request. The write must be ignored.
        applyStimulus("reset_rdata", 1'b1, 1'b1, 1'b1, 9'd0, 32'hFFFFFFFF);
        checkOutput("reset_rdata_lit", rdata, 32'h0);
        applyStimulus("mem0_after_reset", 1'b0, 1'b0, 1'b1, 9'd0, 32'h0);
        checkOutput("mem0_unchanged_lit", rdata, 32'h0);

        // Load addresses 0..4, then read them back on consecutive cycles.
        for (int i = 0; i < 5; i++)
            applyStimulus("load", 1'b0, 1'b1, 1'b0, 9'(i), loadWords[i]);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("read_back", 1'b0, 1'b0, 1'b1, 9'(i), 32'h0);
            checkOutput("read_back_lit", rdata, loadWords[i]);
        end

        // Hold: read address 2, then drop rd and move the address to 4.
        applyStimulus("read2", 1'b0, 1'b0, 1'b1, 9'd2, 32'h0);
        applyStimulus("hold", 1'b0, 1'b0, 1'b0, 9'd4, 32'h0);
        checkOutput("hold_lit", rdata, 32'h21230000);

        // Write-first on a simultaneous read and write.
        applyStimulus("write_first", 1'b0, 1'b1, 1'b1, 9'd7, 32'hDEADBEEF);
        checkOutput("write_first_lit", rdata, 32'hDEADBEEF);
        applyStimulus("read7", 1'b0, 1'b0, 1'b1, 9'd0, 32'h0);
        applyStimulus("read7", 1'b0, 1'b0, 1'b1, 9'd7, 32'h0);
        checkOutput("read7_lit", rdata, 32'hDEADBEEF);

        // Reset in the middle of a read. Array contents must be kept.
        applyStimulus("reload3", 1'b0, 1'b1, 1'b0, 9'd3, 32'h22450000);
        applyStimulus("reset_mid_read", 1'b1, 1'b0, 1'b1, 9'd3, 32'h0);
        checkOutput("reset_mid_read_lit", rdata, 32'h0);
        applyStimulus("after_reset", 1'b0, 1'b0, 1'b1, 9'd3, 32'h0);
        checkOutput("after_reset_lit", rdata, 32'h22450000);

        // Address boundaries and a word that was never written.
        applyStimulus("wr511", 1'b0, 1'b1, 1'b0, 9'd511, 32'hA5A5A5A5);
        applyStimulus("wr0", 1'b0, 1'b1, 1'b0, 9'd0, 32'h5A5A5A5A);
        applyStimulus("rd511", 1'b0, 1'b0, 1'b1, 9'd511, 32'h0);
        checkOutput("rd511_lit", rdata, 32'hA5A5A5A5);
        applyStimulus("rd0", 1'b0, 1'b0, 1'b1, 9'd0, 32'h0);
        checkOutput("rd0_lit", rdata, 32'h5A5A5A5A);
        applyStimulus("rd300", 1'b0, 1'b0, 1'b1, 9'd300, 32'h0);
        checkOutput("rd300_lit", rdata, 32'h0);

        // Random traffic over a small address window to create collisions.
        for (int i = 0; i < 60; i++) begin
            applyStimulus("random", ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          9'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 9'h1F0 : 9'h0),
                          $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
